// File: rtl/move_scheduler.sv
// move_scheduler
//   Sequences piece-motion commands into the game core: level-dependent gravity
//   "down" ticks plus keyboard moves buffered in a small FIFO. One command is
//   offered at a time over cmd_valid/cmd_ready. After the offer is accepted the
//   block waits for cmd_done. A landing starts a spawn lockout, and fail halts
//   the block until rst.
//
//   Optional feature: define SCHED_MERGE_DOWN_EN to discard a down key (100),
//   without counting it as dropped, while a gravity down is pending or in flight.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code[2:0]  100 down, 101 left, 110 right, 111 rotate; 0xx ignored
//   score[6:0]     current score from the core
//   fail           game-over flag from the core
//   cmd_ready      core accepts the offered command this cycle
//   cmd_done       one-cycle pulse: core finished the accepted command
//   cmd_landed     qualifies cmd_done: the piece landed
//   cmd_valid      command offered
//   cmd_code[2:0]  offered command (key_code encoding)
//   level[2:0]     current level
//   fifo_count     queued keyboard commands
//   dropped_keys   keys lost to FIFO overflow, saturating
module move_scheduler #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BASE_PERIOD = 33554432,
   parameter int unsigned MIN_PERIOD  = 1048576,
   parameter int unsigned LEVEL_STEP  = 20,
   parameter int unsigned MAX_LEVEL   = 4,
   parameter int unsigned SPAWN_DELAY = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              key_valid,
   input  logic [2:0]                        key_code,
   input  logic [6:0]                        score,
   input  logic                              fail,
   input  logic                              cmd_ready,
   input  logic                              cmd_done,
   input  logic                              cmd_landed,
   output logic                              cmd_valid,
   output logic [2:0]                        cmd_code,
   output logic [2:0]                        level,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic [7:0]                        dropped_keys
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SPW_W = $clog2(SPAWN_DELAY + 1);
   localparam logic [2:0]  CODE_DOWN = 3'b100;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      SPAWN = 3'd3,
      HALT  = 3'd4
   } stateT;

   stateT state, stateNext;

   logic             keyValidQ;
   logic [2:0]       keyCodeQ;
   logic [2:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [31:0]      gravCnt, basePeriod, period, levelRaw;
   logic             gravPend, gravRun, gravTick;
   logic [SPW_W-1:0] spawnCnt;
   logic             popEn, loadGrav, flush, spawnLoad;
   logic             fifoFull, pushReq, pushEn, dropEn, mergeDrop;

   // Key capture stage: only legal codes (msb set) are forwarded
   always_ff @(posedge clk) begin
      if (rst) begin
         keyValidQ <= 1'b0;
         keyCodeQ  <= 3'b000;
      end else begin
         keyValidQ <= key_valid & key_code[2];
         keyCodeQ  <= key_code;
      end
   end

   // Level from score, and gravity period derived from the registered level
   always_comb begin
      levelRaw   = 32'(score) / LEVEL_STEP;
      basePeriod = 32'(BASE_PERIOD) >> level;
      period     = (basePeriod > 32'(MIN_PERIOD)) ? basePeriod : 32'(MIN_PERIOD);
      gravRun    = (state == IDLE) || (state == ISSUE) || (state == WAIT);
      // >= rather than == so a shortened period takes effect immediately
      gravTick   = gravRun && (gravCnt >= (period - 32'd1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 3'd0;
      end else if (levelRaw > 32'(MAX_LEVEL)) begin
         level <= 3'(MAX_LEVEL);
      end else begin
         level <= levelRaw[2:0];
      end
   end

   // Gravity counter and single pending tick; SPAWN holds both clear
   always_ff @(posedge clk) begin
      if (rst) begin
         gravCnt  <= 32'd0;
         gravPend <= 1'b0;
      end else if (state == SPAWN) begin
         gravCnt  <= 32'd0;
         gravPend <= 1'b0;
      end else begin
         if (gravRun) begin
            gravCnt <= gravTick ? 32'd0 : gravCnt + 32'd1;
         end
         // a tick arriving while one is already pending is lost
         if (loadGrav) begin
            gravPend <= 1'b0;
         end else if (gravTick) begin
            gravPend <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // FSM next state and control strobes
   always_comb begin
      stateNext = state;
      popEn     = 1'b0;
      loadGrav  = 1'b0;
      flush     = 1'b0;
      spawnLoad = 1'b0;
      case (state)
         IDLE: begin
            if (gravPend) begin
               loadGrav  = 1'b1;
               stateNext = ISSUE;
            end else if (fifo_count != CNT_W'(0)) begin
               popEn     = 1'b1;
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_ready) stateNext = WAIT;
         end
         WAIT: begin
            if (cmd_done) begin
               if (cmd_landed) begin
                  stateNext = SPAWN;
                  flush     = 1'b1;
                  spawnLoad = 1'b1;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         SPAWN: begin
            flush = 1'b1;
            if (spawnCnt <= SPW_W'(1)) stateNext = IDLE;
         end
         HALT: begin
            flush = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
      // fail wins from any state; a handshake in this cycle still completes
      if (fail) begin
         stateNext = HALT;
         popEn     = 1'b0;
         loadGrav  = 1'b0;
         spawnLoad = 1'b0;
         flush     = 1'b1;
      end
   end

`ifdef SCHED_MERGE_DOWN_EN
   logic gravInFlight;

   // Tracks whether the command in ISSUE/WAIT came from gravity
   always_ff @(posedge clk) begin
      if (rst) begin
         gravInFlight <= 1'b0;
      end else if (loadGrav) begin
         gravInFlight <= 1'b1;
      end else if (popEn) begin
         gravInFlight <= 1'b0;
      end
   end

   always_comb begin
      mergeDrop = (keyCodeQ == CODE_DOWN) &&
                  (gravPend || (gravInFlight && ((state == ISSUE) || (state == WAIT))));
   end
`else
   always_comb begin
      mergeDrop = 1'b0;
   end
`endif

   // Push qualification; a same-cycle pop frees the slot of a full FIFO
   always_comb begin
      fifoFull = (fifo_count == CNT_W'(FIFO_DEPTH));
      pushReq  = keyValidQ && !flush && !mergeDrop;
      pushEn   = pushReq && (!fifoFull || popEn);
      dropEn   = pushReq && fifoFull && !popEn;
   end

   always_ff @(posedge clk) begin
      if (pushEn) fifoMem[wrPtr] <= keyCodeQ;
   end

   // FIFO pointers, occupancy and overflow counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr        <= '0;
         wrPtr        <= '0;
         fifo_count   <= '0;
         dropped_keys <= 8'd0;
      end else if (flush) begin
         rdPtr      <= '0;
         wrPtr      <= '0;
         fifo_count <= '0;
      end else begin
         if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
         if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
         case ({pushEn, popEn})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (dropEn && (dropped_keys != 8'hFF)) dropped_keys <= dropped_keys + 8'd1;
      end
   end

   // Spawn lockout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         spawnCnt <= '0;
      end else if (spawnLoad) begin
         spawnCnt <= SPW_W'(SPAWN_DELAY);
      end else if ((state == SPAWN) && (spawnCnt != SPW_W'(0))) begin
         spawnCnt <= spawnCnt - SPW_W'(1);
      end
   end

   // Command outputs; cmd_valid mirrors the ISSUE state
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid <= 1'b0;
         cmd_code  <= 3'b000;
      end else begin
         cmd_valid <= (stateNext == ISSUE);
         if (loadGrav) begin
            cmd_code <= CODE_DOWN;
         end else if (popEn) begin
            cmd_code <= fifoMem[rdPtr];
         end
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler
//   Directed bench for move_scheduler with a short gravity period
//   (BASE_PERIOD=16, MIN_PERIOD=4, FIFO_DEPTH=4, SPAWN_DELAY=8, LEVEL_STEP=20).
module tb_move_scheduler;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [2:0] key_code;
   logic [6:0] score;
   logic       fail;
   logic       cmd_ready;
   logic       cmd_done;
   logic       cmd_landed;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [2:0] level;
   logic [2:0] fifo_count;
   logic [7:0] dropped_keys;

   int checks = 0;
   int errors = 0;
   bit autoDone = 1'b0;

   move_scheduler #(
      .FIFO_DEPTH (4),
      .BASE_PERIOD(16),
      .MIN_PERIOD (4),
      .LEVEL_STEP (20),
      .MAX_LEVEL  (4),
      .SPAWN_DELAY(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .score       (score),
      .fail        (fail),
      .cmd_ready   (cmd_ready),
      .cmd_done    (cmd_done),
      .cmd_landed  (cmd_landed),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .level       (level),
      .fifo_count  (fifo_count),
      .dropped_keys(dropped_keys)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       kv;
      logic [2:0] kc;
      logic       rdy;
      logic       ev;
      logic [2:0] ec;
      logic [2:0] ecnt;
      logic [7:0] edrop;
   } vecT;

   function automatic vecT mk(logic kv, logic [2:0] kc, logic rdy, logic ev,
                              logic [2:0] ec, logic [2:0] ecnt, logic [7:0] edrop);
      vecT v;
      v.kv = kv; v.kc = kc; v.rdy = rdy;
      v.ev = ev; v.ec = ec; v.ecnt = ecnt; v.edrop = edrop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock; the emulated core answers an accepted command with cmd_done next cycle
   task automatic step();
      logic acc;
      acc = cmd_valid & cmd_ready;
      @(posedge clk);
      #1;
      if (autoDone) cmd_done = acc;
   endtask

   task automatic doReset();
      autoDone   = 1'b0;
      rst        = 1'b1;
      key_valid  = 1'b0;
      key_code   = 3'b000;
      cmd_done   = 1'b0;
      cmd_landed = 1'b0;
      fail       = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_code", 32'(cmd_code), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_dropped", 32'(dropped_keys), 32'd0);
      rst = 1'b0;
   endtask

   task automatic runVec(input string name, input vecT v);
      key_valid = v.kv;
      key_code  = v.kc;
      cmd_ready = v.rdy;
      step();
      chk({name, "_valid"}, 32'(cmd_valid), 32'(v.ev));
      chk({name, "_code"}, 32'(cmd_code), 32'(v.ec));
      chk({name, "_count"}, 32'(fifo_count), 32'(v.ecnt));
      chk({name, "_dropped"}, 32'(dropped_keys), 32'(v.edrop));
   endtask

   vecT t2[16];
   vecT t3[8];
   logic [6:0] lvScore[8];
   logic [2:0] lvExp[8];
   bit merge;

   initial begin
`ifdef SCHED_MERGE_DOWN_EN
      merge = 1'b1;
`else
      merge = 1'b0;
`endif
      // keys pushed while a gravity down is held in ISSUE, then drained in order
      t2[0]  = mk(1, 3'b101, 0, 1, 3'b100, 3'd0, 8'd0);
      t2[1]  = mk(1, 3'b110, 0, 1, 3'b100, 3'd1, 8'd0);
      t2[2]  = mk(1, 3'b111, 0, 1, 3'b100, 3'd2, 8'd0);
      t2[3]  = mk(0, 3'b000, 1, 0, 3'b100, 3'd3, 8'd0);
      t2[4]  = mk(0, 3'b000, 1, 0, 3'b100, 3'd3, 8'd0);
      t2[5]  = mk(0, 3'b000, 1, 1, 3'b101, 3'd2, 8'd0);
      t2[6]  = mk(0, 3'b000, 1, 0, 3'b101, 3'd2, 8'd0);
      t2[7]  = mk(0, 3'b000, 1, 0, 3'b101, 3'd2, 8'd0);
      t2[8]  = mk(0, 3'b000, 1, 1, 3'b110, 3'd1, 8'd0);
      t2[9]  = mk(0, 3'b000, 1, 0, 3'b110, 3'd1, 8'd0);
      t2[10] = mk(0, 3'b000, 1, 0, 3'b110, 3'd1, 8'd0);
      t2[11] = mk(0, 3'b000, 1, 1, 3'b111, 3'd0, 8'd0);
      t2[12] = mk(0, 3'b000, 1, 0, 3'b111, 3'd0, 8'd0);
      t2[13] = mk(0, 3'b000, 1, 0, 3'b111, 3'd0, 8'd0);
      t2[14] = mk(0, 3'b000, 1, 0, 3'b111, 3'd0, 8'd0);
      t2[15] = mk(0, 3'b000, 1, 1, 3'b100, 3'd0, 8'd0);
      // six keys with cmd_ready low: one held in ISSUE, four queued, one dropped
      t3[0]  = mk(1, 3'b101, 0, 0, 3'b000, 3'd0, 8'd0);
      t3[1]  = mk(1, 3'b110, 0, 0, 3'b000, 3'd1, 8'd0);
      t3[2]  = mk(1, 3'b111, 0, 1, 3'b101, 3'd1, 8'd0);
      t3[3]  = mk(1, 3'b101, 0, 1, 3'b101, 3'd2, 8'd0);
      t3[4]  = mk(1, 3'b110, 0, 1, 3'b101, 3'd3, 8'd0);
      t3[5]  = mk(1, 3'b111, 0, 1, 3'b101, 3'd4, 8'd0);
      t3[6]  = mk(0, 3'b000, 0, 1, 3'b101, 3'd4, 8'd1);
      t3[7]  = mk(0, 3'b000, 0, 1, 3'b101, 3'd4, 8'd1);
      lvScore = '{7'd0, 7'd19, 7'd20, 7'd39, 7'd40, 7'd79, 7'd80, 7'd127};
      lvExp   = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

      rst = 1'b1; key_valid = 1'b0; key_code = 3'b000; score = 7'd0;
      fail = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; cmd_landed = 1'b0;

      // gravity only: one down every 16 cycles
      doReset();
      cmd_ready = 1'b1;
      autoDone  = 1'b1;
      for (int e = 1; e <= 52; e++) begin
         step();
         chk("grav_valid", 32'(cmd_valid), 32'((e == 17) || (e == 33) || (e == 49)));
         if (e == 17 || e == 33 || e == 49) chk("grav_code", 32'(cmd_code), 32'd4);
      end

      // queued keys issued in order after the gravity command
      doReset();
      cmd_ready = 1'b0;
      autoDone  = 1'b1;
      repeat (17) step();
      chk("t2_first_valid", 32'(cmd_valid), 32'd1);
      chk("t2_first_code", 32'(cmd_code), 32'd4);
      for (int i = 0; i < 16; i++) runVec("t2", t2[i]);
      key_valid = 1'b0;

      // overflow while the core stalls
      doReset();
      for (int i = 0; i < 8; i++) runVec("t3", t3[i]);
      key_valid = 1'b0;

      // gravity beats a queued key
      doReset();
      cmd_ready = 1'b1;
      key_valid = 1'b1; key_code = 3'b110;
      step();
      key_valid = 1'b0;
      step(); step();
      chk("t4_key_issue", 32'(cmd_code), 32'd6);
      step();
      key_valid = 1'b1; key_code = 3'b101;
      step();
      key_valid = 1'b0;
      step();
      chk("t4_queued", 32'(fifo_count), 32'd1);
      repeat (10) step();
      chk("t4_wait_valid", 32'(cmd_valid), 32'd0);
      cmd_done = 1'b1;
      key_valid = 1'b1; key_code = 3'b100;
      step();
      cmd_done = 1'b0;
      key_valid = 1'b0;
      step();
      chk("t4_grav_valid", 32'(cmd_valid), 32'd1);
      chk("t4_grav_code", 32'(cmd_code), 32'd4);
      chk("t4_grav_count", 32'(fifo_count), merge ? 32'd1 : 32'd2);
      step();
      chk("t4_accept", 32'(cmd_valid), 32'd0);
      cmd_done = 1'b1;
      step();
      cmd_done = 1'b0;
      step();
      chk("t4_key_valid", 32'(cmd_valid), 32'd1);
      chk("t4_key_code", 32'(cmd_code), 32'd5);
      chk("t4_key_count", 32'(fifo_count), merge ? 32'd0 : 32'd1);
      chk("t4_dropped", 32'(dropped_keys), 32'd0);

      // landing flushes the FIFO and starts the spawn lockout
      doReset();
      cmd_ready = 1'b1;
      key_valid = 1'b1; key_code = 3'b110;
      step();
      key_valid = 1'b0;
      step(); step(); step();
      key_valid = 1'b1; key_code = 3'b101;
      step();
      key_code = 3'b111;
      step();
      key_valid = 1'b0;
      step();
      chk("t5_queued", 32'(fifo_count), 32'd2);
      cmd_done = 1'b1; cmd_landed = 1'b1;
      key_valid = 1'b1; key_code = 3'b101;
      step();
      cmd_done = 1'b0; cmd_landed = 1'b0;
      chk("t5_flush", 32'(fifo_count), 32'd0);
      for (int i = 0; i < 8; i++) begin
         key_valid = (i < 3);
         step();
         chk("t5_spawn_valid", 32'(cmd_valid), 32'd0);
         chk("t5_spawn_count", 32'(fifo_count), 32'd0);
      end
      key_valid = 1'b0;
      chk("t5_spawn_dropped", 32'(dropped_keys), 32'd0);
      repeat (16) begin
         step();
         chk("t5_post_valid", 32'(cmd_valid), 32'd0);
      end
      step();
      chk("t5_grav_restart", 32'(cmd_valid), 32'd1);
      chk("t5_grav_code", 32'(cmd_code), 32'd4);

      // level mapping and saturation
      doReset();
      for (int i = 0; i < 8; i++) begin
         score = lvScore[i];
         step();
         chk("level_map", 32'(level), 32'(lvExp[i]));
      end

      // level 2: gravity every 4 cycles, then fail during ISSUE
      score = 7'd40;
      doReset();
      cmd_ready = 1'b1;
      autoDone  = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step();
         if (e == 1) chk("t6_level", 32'(level), 32'd2);
         chk("t6_valid", 32'(cmd_valid), 32'((e == 5) || (e == 9) || (e == 13)));
      end
      fail = 1'b1;
      step();
      fail = 1'b0;
      chk("t6_fail_valid", 32'(cmd_valid), 32'd0);
      for (int i = 0; i < 24; i++) begin
         key_valid = (i < 4);
         key_code  = 3'b110;
         step();
         chk("t6_halt_valid", 32'(cmd_valid), 32'd0);
      end
      key_valid = 1'b0;
      chk("t6_halt_count", 32'(fifo_count), 32'd0);
      doReset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
